// File: rtl/cfg_counter.sv
// Configurable prescaled counter: up-wrap, down-wrap, up-saturate and up/down bounce modes.
// Optional compare unit is built only when CFG_COUNTER_CMP_EN is defined.
module cfg_counter #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [PRESC_W-1:0] prescale,
  input  logic [WIDTH-1:0]   top,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  input  logic [WIDTH-1:0]   cmp_val,
  output logic [WIDTH-1:0]   count,
  output logic               dir,
  output logic               tc,
  output logic               cmp_match
);

  typedef enum logic [1:0] {
    MODE_UP_WRAP   = 2'b00,
    MODE_DOWN_WRAP = 2'b01,
    MODE_UP_SAT    = 2'b10,
    MODE_BOUNCE    = 2'b11
  } mode_e;

  logic [PRESC_W-1:0] pcnt_reg, pcnt_next;
  logic [WIDTH-1:0]   count_reg, count_next;
  logic               dir_reg, dir_next;
  logic               tc_reg, tc_next;
  logic               tick;
  logic [WIDTH-1:0]   count_inc, count_dec;

  always_comb begin
    tick       = en && (pcnt_reg == prescale);
    count_inc  = count_reg + WIDTH'(1);
    count_dec  = count_reg - WIDTH'(1);
    pcnt_next  = pcnt_reg;
    count_next = count_reg;
    // direction is only meaningful in bounce mode; every other mode parks it at 0
    dir_next   = (mode_e'(mode) == MODE_BOUNCE) ? dir_reg : 1'b0;
    tc_next    = 1'b0;

    if (load) begin
      count_next = load_val;
      pcnt_next  = '0;
      dir_next   = 1'b0;
    end else begin
      if (en)
        pcnt_next = tick ? '0 : pcnt_reg + PRESC_W'(1);
      if (tick) begin
        unique case (mode_e'(mode))
          MODE_UP_WRAP: begin
            if (count_reg >= top) begin
              count_next = '0;
              tc_next    = 1'b1;
            end else begin
              count_next = count_inc;
            end
          end
          MODE_DOWN_WRAP: begin
            if (count_reg == '0 || count_reg > top) begin
              count_next = top;
              tc_next    = (count_reg == '0);
            end else begin
              count_next = count_dec;
            end
          end
          MODE_UP_SAT: begin
            if (count_reg < top) begin
              count_next = count_inc;
              tc_next    = (count_inc == top);
            end else begin
              count_next = top;
            end
          end
          MODE_BOUNCE: begin
            // a zero ceiling leaves nowhere to bounce: pin at 0, counting up
            if (top == '0) begin
              count_next = '0;
              dir_next   = 1'b0;
            end else if (!dir_reg) begin
              if (count_reg > top) begin
                count_next = top;
                dir_next   = 1'b1;
              end else begin
                count_next = count_inc;
                dir_next   = (count_inc >= top);
              end
            end else begin
              count_next = count_dec;
              if (count_dec == '0) begin
                dir_next = 1'b0;
                tc_next  = 1'b1;
              end
            end
          end
          default: count_next = count_reg;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_reg  <= '0;
      count_reg <= '0;
      dir_reg   <= 1'b0;
      tc_reg    <= 1'b0;
    end else begin
      pcnt_reg  <= pcnt_next;
      count_reg <= count_next;
      dir_reg   <= dir_next;
      tc_reg    <= tc_next;
    end
  end

  assign count = count_reg;
  assign dir   = dir_reg;
  assign tc    = tc_reg;

`ifdef CFG_COUNTER_CMP_EN
  logic cmp_reg;

  // compare against the value being loaded into count so the flag lines up with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cmp_reg <= 1'b0;
    else
      cmp_reg <= (count_next == cmp_val);
  end

  assign cmp_match = cmp_reg;
`else
  logic unused_cmp;

  assign unused_cmp = ^cmp_val;
  assign cmp_match  = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_counter.sv
// Scoreboard bench for cfg_counter: expected outputs are queued as each cycle is driven
// and popped after the clock edge that produces them.
module tb_cfg_counter;
  localparam int WIDTH   = 8;
  localparam int PRESC_W = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic [1:0]         mode;
  logic [PRESC_W-1:0] prescale;
  logic [WIDTH-1:0]   top;
  logic               load;
  logic [WIDTH-1:0]   load_val;
  logic [WIDTH-1:0]   cmp_val;
  logic [WIDTH-1:0]   count;
  logic               dir;
  logic               tc;
  logic               cmp_match;

  typedef struct packed {
    logic [WIDTH-1:0] count;
    logic             dir;
    logic             tc;
    logic             cmp;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cfg_counter #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .mode     (mode),
    .prescale (prescale),
    .top      (top),
    .load     (load),
    .load_val (load_val),
    .cmp_val  (cmp_val),
    .count    (count),
    .dir      (dir),
    .tc       (tc),
    .cmp_match(cmp_match)
  );

  function automatic logic exp_cmp(input logic [WIDTH-1:0] c);
`ifdef CFG_COUNTER_CMP_EN
    return (c == cmp_val);
`else
    return 1'b0;
`endif
  endfunction

  // queue the expectation for the inputs now applied, then advance one edge
  task automatic push_cycle(input logic [WIDTH-1:0] c, input logic d, input logic t);
    obs_t e;
    e.count = c;
    e.dir   = d;
    e.tc    = t;
    e.cmp   = exp_cmp(c);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t got;
    rst_n = 1'b1; en = 1'b1; mode = 2'b00; prescale = '0; top = 8'd9;
    load = 1'b0; load_val = '0; cmp_val = 8'd7;
    #1 rst_n = 1'b0;
    #1;
    got = {count, dir, tc, cmp_match};
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL reset_async got count=%0d dir=%b tc=%b cmp=%b want all 0", got.count, got.dir, got.tc, got.cmp);
    end else $display("reset_async count=%0d ok", got.count);
    repeat (2) @(posedge clk);
    #1;
    got = {count, dir, tc, cmp_match};
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL reset_held got count=%0d dir=%b tc=%b cmp=%b want all 0", got.count, got.dir, got.tc, got.cmp);
    end else $display("reset_held count=%0d ok", got.count);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      obs_t want;
      push_cycle(WIDTH'(i + 1), 1'b0, 1'b0);
      got = {count, dir, tc, cmp_match}; want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_release[%0d] got count=%0d dir=%b tc=%b cmp=%b want count=%0d dir=%b tc=%b cmp=%b",
                 i, got.count, got.dir, got.tc, got.cmp, want.count, want.dir, want.tc, want.cmp);
      end else $display("reset_release[%0d] count=%0d ok", i, got.count);
    end
  endtask

  task automatic test_wrap();
    obs_t got, want;
    mode = 2'b00; prescale = '0; top = 8'd9; en = 1'b1; cmp_val = 8'd7;
    load = 1'b1; load_val = '0;
    for (int k = 0; k <= 22; k++) begin
      if (k == 0) push_cycle('0, 1'b0, 1'b0);
      else        push_cycle(WIDTH'(k % 10), 1'b0, (k % 10) == 0);
      load = 1'b0;
      got = {count, dir, tc, cmp_match}; want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL wrap[%0d] got count=%0d dir=%b tc=%b cmp=%b want count=%0d dir=%b tc=%b cmp=%b",
                 k, got.count, got.dir, got.tc, got.cmp, want.count, want.dir, want.tc, want.cmp);
      end else $display("wrap[%0d] count=%0d tc=%b cmp=%b ok", k, got.count, got.tc, got.cmp);
    end
  endtask

  task automatic test_prescale();
    obs_t got, want;
    int   enabled = 0;
    mode = 2'b00; prescale = 4'd2; top = 8'd200; en = 1'b1; cmp_val = 8'd3;
    load = 1'b1; load_val = '0;
    push_cycle('0, 1'b0, 1'b0);
    load = 1'b0;
    got = {count, dir, tc, cmp_match}; want = exp_q.pop_front(); checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL presc_load got count=%0d want count=%0d", got.count, want.count);
    end else $display("presc_load count=%0d ok", got.count);
    for (int i = 0; i < 20; i++) begin
      en = !(i >= 7 && i < 12);
      if (en) enabled++;
      push_cycle(WIDTH'(enabled / 3), 1'b0, 1'b0);
      got = {count, dir, tc, cmp_match}; want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL presc[%0d] en=%b got count=%0d dir=%b tc=%b cmp=%b want count=%0d dir=%b tc=%b cmp=%b",
                 i, en, got.count, got.dir, got.tc, got.cmp, want.count, want.dir, want.tc, want.cmp);
      end else $display("presc[%0d] en=%b count=%0d cmp=%b ok", i, en, got.count, got.cmp);
    end
    en = 1'b1;
  endtask

  task automatic test_bounce();
    obs_t             got, want;
    logic [WIDTH-1:0] sc [11] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd2, 8'd1, 8'd0, 8'd1, 8'd2, 8'd3, 8'd3};
    logic             sd [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic             st [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    mode = 2'b11; prescale = '0; top = 8'd3; en = 1'b1; cmp_val = 8'd2;
    load = 1'b1; load_val = '0;
    for (int i = 0; i < 12; i++) begin
      if (i == 10) en = 1'b0;
      if (i == 11) mode = 2'b00;
      if (i < 11) push_cycle(sc[i], sd[i], st[i]);
      else        push_cycle(8'd3, 1'b0, 1'b0);
      load = 1'b0;
      got = {count, dir, tc, cmp_match}; want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL bounce[%0d] got count=%0d dir=%b tc=%b cmp=%b want count=%0d dir=%b tc=%b cmp=%b",
                 i, got.count, got.dir, got.tc, got.cmp, want.count, want.dir, want.tc, want.cmp);
      end else $display("bounce[%0d] count=%0d dir=%b tc=%b ok", i, got.count, got.dir, got.tc);
    end
    en = 1'b1;
  endtask

  task automatic test_saturate();
    obs_t got, want;
    mode = 2'b10; prescale = '0; top = 8'd200; en = 1'b1; cmp_val = 8'd200;
    load = 1'b1; load_val = 8'd198;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0:       push_cycle(8'd198, 1'b0, 1'b0);
        1:       push_cycle(8'd199, 1'b0, 1'b0);
        2:       push_cycle(8'd200, 1'b0, 1'b1);
        default: push_cycle(8'd200, 1'b0, 1'b0);
      endcase
      load = 1'b0;
      got = {count, dir, tc, cmp_match}; want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL sat[%0d] got count=%0d dir=%b tc=%b cmp=%b want count=%0d dir=%b tc=%b cmp=%b",
                 i, got.count, got.dir, got.tc, got.cmp, want.count, want.dir, want.tc, want.cmp);
      end else $display("sat[%0d] count=%0d tc=%b ok", i, got.count, got.tc);
    end
  endtask

  task automatic test_down_and_reset();
    obs_t             got, want;
    logic [WIDTH-1:0] sc [4] = '{8'd0, 8'd5, 8'd4, 8'd3};
    logic             st [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    mode = 2'b01; prescale = '0; top = 8'd5; en = 1'b1; cmp_val = 8'd4;
    // prescaler is at 0 == prescale, so a tick coincides with this load
    load = 1'b1; load_val = '0;
    for (int i = 0; i < 4; i++) begin
      push_cycle(sc[i], 1'b0, st[i]);
      load = 1'b0;
      got = {count, dir, tc, cmp_match}; want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL down[%0d] got count=%0d dir=%b tc=%b cmp=%b want count=%0d dir=%b tc=%b cmp=%b",
                 i, got.count, got.dir, got.tc, got.cmp, want.count, want.dir, want.tc, want.cmp);
      end else $display("down[%0d] count=%0d tc=%b ok", i, got.count, got.tc);
    end
    #2 rst_n = 1'b0;
    #1;
    got = {count, dir, tc, cmp_match}; checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL down_async_reset got count=%0d dir=%b tc=%b cmp=%b want all 0", got.count, got.dir, got.tc, got.cmp);
    end else $display("down_async_reset count=%0d ok", got.count);
    prescale = 4'd2;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i < 2)       push_cycle(8'd0, 1'b0, 1'b0);
      else if (i == 2) push_cycle(8'd5, 1'b0, 1'b1);
      else             push_cycle(8'd5, 1'b0, 1'b0);
      got = {count, dir, tc, cmp_match}; want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL down_release[%0d] got count=%0d dir=%b tc=%b cmp=%b want count=%0d dir=%b tc=%b cmp=%b",
                 i, got.count, got.dir, got.tc, got.cmp, want.count, want.dir, want.tc, want.cmp);
      end else $display("down_release[%0d] count=%0d tc=%b ok", i, got.count, got.tc);
    end
  endtask

  task automatic test_top_zero();
    obs_t got, want;
    prescale = '0; top = '0; en = 1'b1; cmp_val = 8'd0;
    for (int m = 0; m < 4; m++) begin
      mode = 2'(m);
      load = 1'b1; load_val = '0;
      for (int i = 0; i < 4; i++) begin
        push_cycle('0, 1'b0, (i > 0) && (m < 2));
        load = 1'b0;
        got = {count, dir, tc, cmp_match}; want = exp_q.pop_front(); checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL top0 mode=%0d[%0d] got count=%0d dir=%b tc=%b cmp=%b want count=%0d dir=%b tc=%b cmp=%b",
                   m, i, got.count, got.dir, got.tc, got.cmp, want.count, want.dir, want.tc, want.cmp);
        end else $display("top0 mode=%0d[%0d] count=%0d tc=%b ok", m, i, got.count, got.tc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_prescale();
    test_bounce();
    test_saturate();
    test_down_and_reset();
    test_top_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cfg_counter.md
CFG_COUNTER -- requirements
Module: cfg_counter

Interface
REQ-001 SHALL have parameter: WIDTH, 8, counter width in bits (2..16).
REQ-002 SHALL have parameter: PRESC_W, 4, prescaler width in bits (1..8).
REQ-003 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: en  input  1  count enable; 0 freezes prescaler and counter.
REQ-006 SHALL have port: mode  input  2  00 up-wrap, 01 down-wrap, 10 up-saturate, 11 up/down bounce.
REQ-007 SHALL have port: prescale  input  PRESC_W  counter advances once per prescale+1 enabled cycles.
REQ-008 SHALL have port: top  input  WIDTH  upper limit for wrap/saturate/bounce.
REQ-009 SHALL have port: load  input  1  synchronous load strobe.
REQ-010 SHALL have port: load_val  input  WIDTH  value written on load.
REQ-011 SHALL have port: cmp_val  input  WIDTH  compare value.
REQ-012 SHALL have port: count  output  WIDTH  registered counter value.
REQ-013 SHALL have port: dir  output  1  registered direction, 1 = counting down.
REQ-014 SHALL have port: tc  output  1  registered one-cycle terminal-count pulse.
REQ-015 SHALL have port: cmp_match  output  1  registered compare flag.

Function
REQ-016 SHALL hold an internal prescaler pcnt; with en=1, tick=1 when pcnt==prescale and pcnt<=0, else pcnt<=pcnt+1; en=0 holds pcnt, tick=0.
REQ-017 SHALL give load priority over tick and en: count<=load_val, pcnt<=0, dir<=0, tc<=0.
REQ-018 SHALL, mode 00 on tick: count>=top -> count<=0, tc<=1; else count<=count+1.
REQ-019 SHALL, mode 01 on tick: count==0 or count>top -> count<=top, tc<=1 only if count==0; else count<=count-1.
REQ-020 SHALL, mode 10 on tick: count<top -> count<=count+1, tc<=1 iff count+1==top; count>=top -> count<=top, tc<=0.
REQ-021 SHALL, mode 11 on tick: dir=0 -> count+1, dir<=1 when count+1>=top; dir=1 -> count-1, dir<=0 and tc<=1 when count-1==0; count>top while dir=0 -> count<=top, dir<=1.
REQ-022 SHALL, with top==0, hold count at 0 in all modes, dir=0; tc pulses each tick in modes 00/01 only.
REQ-023 SHALL deassert tc on every cycle without a qualifying tick event.
REQ-024 SHALL force dir<=0 whenever mode!=11; mode/top/prescale changes take effect at the next clock edge.
REQ-025 SHALL perform all count arithmetic modulo 2^WIDTH with no carry out.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously clear count, pcnt, dir, tc, cmp_match to 0.
REQ-027 SHALL release reset synchronously to clk; first tick occurs prescale+1 enabled cycles after release.

Configuration
REQ-028 SHALL compile the compare unit only when macro CFG_COUNTER_CMP_EN is defined: cmp_match<=1 on each edge where next count==cmp_val, else 0.
REQ-029 SHALL, without CFG_COUNTER_CMP_EN, tie cmp_match to 0, ignore cmp_val, keep the port list unchanged.

Verification
REQ-030 SHALL cover: mode 00, prescale 0, top 9, en=1 -> count 0..9,0 repeating; tc=1 each cycle count returns to 0 (period 10).
REQ-031 SHALL cover: mode 00, prescale 2, en low 5 cycles mid-run -> increments every 3 enabled cycles; count and pcnt frozen during en=0.
REQ-032 SHALL cover: mode 11, top 3 -> count 0,1,2,3,2,1,0,1; dir=1 on count 3,2,1; tc=1 on each return to 0.
REQ-033 SHALL cover: mode 10, top 200, load 198 -> 199, 200, 200...; tc high exactly one cycle (count=200).
REQ-034 SHALL cover: mode 01, top 5, load 0 with tick same cycle -> count 0 (load wins); next ticks 5(tc=1),4,3; rst_n low mid-run -> count 0 immediately without clock.
REQ-035 SHALL cover: CFG_COUNTER_CMP_EN defined, mode 00, top 9, cmp_val 7 -> cmp_match=1 only while count=7; undefined -> cmp_match stays 0.
